// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential mult/div units: operand width and
// the handshake FSM state encoding.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_CALC  = 3'd1,
        DIV_FIX   = 3'd2,
        DIV_DONE  = 3'd3,
        DIV_DZERO = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,q} left,
// trial-subtract the divisor, keep the result and set q[0] when it does not borrow.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           borrow;
    logic           take;

    assign rem_sh = {rem, q[WIDTH-1]};
    assign {borrow, diff} = {1'b0, rem_sh} - {2'b00, divisor};

    // rem < divisor always holds, so a non-borrowing difference never sets diff[WIDTH].
    assign take     = ~(borrow | diff[WIDTH]);
    assign rem_next = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], take};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider for MIPS DIV: quotient to lo, remainder to hi,
// with a level DivCtrl request and level DivOut/divZero responses.
//
//  state | meaning
//  IDLE  | waiting for DivCtrl; accepts operands
//  CALC  | one restoring iteration per cycle, WIDTH cycles
//  FIX   | apply signs, load hi/lo
//  DONE  | DivOut held until DivCtrl falls
//  DZERO | divZero held until DivCtrl falls
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             DivOut,
    output logic             divZero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;

    // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= DIV_IDLE;
            hi      <= '0;
            lo      <= '0;
            DivOut  <= 1'b0;
            divZero <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            rem     <= '0;
            q       <= '0;
            divisor <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (DivCtrl) begin
                        if (b == '0) begin
                            state <= DIV_DZERO;
                        end else begin
                            q       <= a_mag;
                            divisor <= b_mag;
                            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r  <= a[WIDTH-1];
                            rem     <= '0;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!DivCtrl) begin
                        busy  <= 1'b0;
                        state <= DIV_IDLE;
                    end else begin
                        rem   <= rem_next;
                        q     <= q_next;
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            state <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: begin
                    busy <= 1'b0;
                    if (!DivCtrl) begin
                        state <= DIV_IDLE;
                    end else begin
                        lo    <= sign_q ? -q : q;
                        hi    <= sign_r ? -rem : rem;
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!DivCtrl) begin
                        DivOut <= 1'b0;
                        state  <= DIV_IDLE;
                    end else begin
                        DivOut <= 1'b1;
                    end
                end
                DIV_DZERO: begin
                    if (!DivCtrl) begin
                        divZero <= 1'b0;
                        state   <= DIV_IDLE;
                    end else begin
                        divZero <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    DivOut  <= 1'b0;
                    divZero <= 1'b0;
                    state   <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider: the driver queues expected results
// from a plain-arithmetic model, the monitor checks each response as it appears.
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_ctrl = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        DivOut;
    logic        divZero;
    logic        busy;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    exp_t        sb[$];

    seq_divider dut (
        .clk     (clk),
        .reset   (reset),
        .DivCtrl (div_ctrl),
        .a       (a_i),
        .b       (b_i),
        .hi      (hi),
        .lo      (lo),
        .DivOut  (DivOut),
        .divZero (divZero),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating signed division at 64 bits, so MIN/-1 does not trap.
    task automatic model(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sbv;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        rl  = 32'(sa / sbv);
        rh  = 32'(sa % sbv);
    endtask

    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input int hold);
        exp_t e;
        int   n;
        logic [31:0] rh, rl;
        @(negedge clk);
        a_i = av;
        b_i = bv;
        div_ctrl = 1'b1;
        e.dz = (bv == 0);
        if (!e.dz) begin
            model(av, bv, rh, rl);
            mhi = rh;
            mlo = rl;
        end
        e.hi  = mhi;
        e.lo  = mlo;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        a_i = $urandom;
        b_i = $urandom;
        n = 0;
        while (!(DivOut || divZero) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout: no DivOut/divZero for a=%h b=%h", av, bv);
        end
        repeat (hold) begin
            @(negedge clk);
            chk("flags_held", {30'd0, DivOut, divZero}, e.dz ? 32'd1 : 32'd2);
            chk("no_restart_busy", {31'd0, busy}, 32'd0);
        end
        div_ctrl = 1'b0;
        @(negedge clk);
        chk("flags_released", {29'd0, DivOut, divZero, busy}, 32'd0);
    endtask

    task automatic do_abort(input logic [31:0] av, input logic [31:0] bv, input int k,
                            input bit use_reset);
        @(negedge clk);
        a_i = av;
        b_i = bv;
        div_ctrl = 1'b1;
        repeat (k) @(negedge clk);
        chk("busy_in_calc", {31'd0, busy}, 32'd1);
        div_ctrl = 1'b0;
        if (use_reset) begin
            reset = 1'b1;
            mhi = '0;
            mlo = '0;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("abort_flags", {29'd0, DivOut, divZero, busy}, 32'd0);
        chk("abort_hi", hi, mhi);
        chk("abort_lo", lo, mlo);
        repeat (40) @(negedge clk);
        chk("abort_no_divout", {31'd0, DivOut}, 32'd0);
    endtask

    // Monitor: pops one expectation on every rising DivOut/divZero.
    initial begin
        bit   pdo, pdz;
        exp_t e;
        pdo = 1'b0;
        pdz = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && ((DivOut && !pdo) || (divZero && !pdz))) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: DivOut=%0b divZero=%0b with nothing outstanding",
                             DivOut, divZero);
                end else begin
                    e = sb.pop_front();
                    chk("divzero_flag", {31'd0, divZero}, {31'd0, e.dz});
                    chk("divout_flag", {31'd0, DivOut}, {31'd0, !e.dz});
                    chk("lo", lo, e.lo);
                    chk("hi", hi, e.hi);
                    chk("latency", 32'(cyc), 32'(e.acc + (e.dz ? 1 : W + 2)));
                end
            end
            pdo = DivOut;
            pdz = divZero;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int r;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_flags", {29'd0, DivOut, divZero, busy}, 32'd0);
        reset = 1'b0;

        do_div(32'd100, 32'd7, 3);
        do_div(-32'd100, 32'd7, 0);
        do_div(32'd100, -32'd7, 1);
        do_div(-32'd100, -32'd7, 0);
        do_div(32'd5, 32'd0, 2);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_div(32'd7, 32'd100, 0);
        do_div(32'd0, 32'd9, 0);
        do_div(32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_div(32'h8000_0000, 32'd1, 0);

        do_abort(32'd12345, 32'd17, 11, 1'b1);
        do_div(32'd1000, 32'd33, 0);
        do_abort(32'd999, 32'd4, 11, 1'b0);
        do_div(-32'd77, 32'd5, 0);

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 500));
            if (r == 0) rb = 32'd0;
            else if (r < 4) rb = 32'($urandom_range(1, 20));
            else rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            do_div(ra, rb, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
